// File: rtl/debounce_filter_bank_if.sv
// debounce_filter_bank_if: groups the raw inputs and filtered outputs of the
// debounce filter bank. master = control logic / stimulus side, slave = filter.
interface debounce_filter_bank_if #(
  parameter int CH_NUM = 4
);
  logic [CH_NUM-1:0] iSignal;
  logic [CH_NUM-1:0] oLevel;
  logic [CH_NUM-1:0] oRise;
  logic [CH_NUM-1:0] oFall;
  logic              oAny;

  modport master (
    output iSignal,
    input  oLevel,
    input  oRise,
    input  oFall,
    input  oAny
  );

  modport slave (
    input  iSignal,
    output oLevel,
    output oRise,
    output oFall,
    output oAny
  );
endinterface

// File: rtl/debounce_filter_bank.sv
// debounce_filter_bank: CH_NUM independent debounce filters. A channel's level
// only moves after FILTER_NUM consecutive samples disagree with it; each
// accepted change emits a one-cycle rise or fall pulse aligned with the level.
// Optional macro DEBOUNCE_SYNC_EN inserts a two-flop synchroniser per channel
// in front of the sample register (+2 cycles latency).
module debounce_filter_bank #(
  parameter int   CH_NUM     = 4,
  parameter int   FILTER_NUM = 10,
  parameter logic INIT_LEVEL = 1'b1
) (
  input logic                    CLK,
  input logic                    RST_n,
  debounce_filter_bank_if.slave  bus
);

  localparam int CNT_W = (FILTER_NUM > 1) ? $clog2(FILTER_NUM) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_NUM - 1);

  logic [CH_NUM-1:0] lvl_vec;
  logic [CH_NUM-1:0] rise_vec;
  logic [CH_NUM-1:0] fall_vec;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic             smp_in;
      logic             smp_q;
      logic             lvl_q,  lvl_d;
      logic [CNT_W-1:0] cnt_q,  cnt_d;
      logic             rise_q, rise_d;
      logic             fall_q, fall_d;

`ifdef DEBOUNCE_SYNC_EN
      logic [1:0] sync_q;

      // Two-flop synchroniser, idles at the reset level so release is quiet
      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) sync_q <= {2{INIT_LEVEL}};
        else        sync_q <= {sync_q[0], bus.iSignal[gi]};
      end

      assign smp_in = sync_q[1];
`else
      assign smp_in = bus.iSignal[gi];
`endif

      // Sample register: the value the filter compares against the level
      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) smp_q <= INIT_LEVEL;
        else        smp_q <= smp_in;
      end

      // Next state: count disagreeing samples, accept on the FILTER_NUM-th
      always_comb begin
        lvl_d  = lvl_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (smp_q != lvl_q) begin
          if (cnt_q == CNT_MAX) begin
            lvl_d  = smp_q;
            rise_d = smp_q;
            fall_d = ~smp_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Level, counter and pulse registers; reset discards any partial count
      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
          lvl_q  <= INIT_LEVEL;
          cnt_q  <= '0;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          lvl_q  <= lvl_d;
          cnt_q  <= cnt_d;
          rise_q <= rise_d;
          fall_q <= fall_d;
        end
      end

      assign lvl_vec[gi]  = lvl_q;
      assign rise_vec[gi] = rise_q;
      assign fall_vec[gi] = fall_q;
    end
  endgenerate

  assign bus.oLevel = lvl_vec;
  assign bus.oRise  = rise_vec;
  assign bus.oFall  = fall_vec;
  assign bus.oAny   = |{rise_vec, fall_vec};

endmodule

// File: tb/tb_debounce_filter_bank.sv
// tb_debounce_filter_bank: directed scenarios plus randomized traffic, each
// cycle compared against a window-based reference model of the filter.
module tb_debounce_filter_bank;

  localparam int   CH   = 4;
  localparam int   F    = 10;
  localparam logic INIT = 1'b1;
`ifdef DEBOUNCE_SYNC_EN
  localparam int   D    = 2;
`else
  localparam int   D    = 0;
`endif
  localparam int   LAT  = F + D;
  localparam int   HN   = F + D;

  logic CLK   = 1'b0;
  logic RST_n = 1'b1;

  int checks   = 0;
  int failures = 0;

  debounce_filter_bank_if #(.CH_NUM(CH)) bus ();

  debounce_filter_bank #(
    .CH_NUM    (CH),
    .FILTER_NUM(F),
    .INIT_LEVEL(INIT)
  ) dut (
    .CLK  (CLK),
    .RST_n(RST_n),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Reference model: a level flips when the last F samples seen by the
  // filter all disagree with it. hist[k] = raw input captured k+1 edges ago.
  logic [CH-1:0] hist [0:HN-1];
  logic [CH-1:0] m_lvl, m_rise, m_fall;
  logic          m_any;
  assign m_any = |{m_rise, m_fall};

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int k = 0; k < HN; k++) hist[k] <= {CH{INIT}};
      m_lvl  <= {CH{INIT}};
      m_rise <= '0;
      m_fall <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = D; k < D + F; k++)
          if (hist[k][c] == m_lvl[c]) all_diff = 1'b0;
        m_lvl[c]  <= all_diff ? ~m_lvl[c] : m_lvl[c];
        m_rise[c] <= all_diff && !m_lvl[c];
        m_fall[c] <= all_diff && m_lvl[c];
      end
      for (int k = HN - 1; k > 0; k--) hist[k] <= hist[k-1];
      hist[0] <= bus.iSignal;
    end
  end

  task automatic test_reset();
    bus.iSignal = {CH{1'b1}};
    #1 RST_n = 1'b0;
    #2;
    checks++;
    if (bus.oLevel !== 4'b1111) begin
      failures++; $display("FAIL reset_level: got %b exp 1111", bus.oLevel);
    end
    checks++;
    if (bus.oRise !== 4'b0000 || bus.oFall !== 4'b0000 || bus.oAny !== 1'b0) begin
      failures++; $display("FAIL reset_pulses: got rise=%b fall=%b any=%b exp 0", bus.oRise, bus.oFall, bus.oAny);
    end
    repeat (3) @(negedge CLK);
    RST_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      checks++;
      if (bus.oAny !== 1'b0 || bus.oLevel !== 4'b1111) begin
        failures++; $display("FAIL reset_release: cyc %0d got lvl=%b any=%b exp 1111/0", i, bus.oLevel, bus.oAny);
      end
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_clean_press();
    int first_low = -1, fall_at = -1, fall_cnt = 0, any_cnt = 0;
    int first_high = -1, rise_at = -1, rise_cnt = 0;
    bus.iSignal[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oAny} !== {m_lvl, m_rise, m_fall, m_any}) begin
        failures++; $display("FAIL press_model: cyc %0d got %b/%b/%b/%b exp %b/%b/%b/%b", i, bus.oLevel, bus.oRise, bus.oFall, bus.oAny, m_lvl, m_rise, m_fall, m_any);
      end
      if (bus.oLevel[0] === 1'b0 && first_low < 0) first_low = i;
      if (bus.oFall[0] === 1'b1) begin fall_cnt++; fall_at = i; end
      if (bus.oAny === 1'b1) any_cnt++;
    end
    checks++;
    if (first_low != LAT || fall_at != LAT) begin
      failures++; $display("FAIL press_latency: got level@%0d fall@%0d exp %0d", first_low, fall_at, LAT);
    end
    checks++;
    if (fall_cnt != 1 || any_cnt != 1) begin
      failures++; $display("FAIL press_pulse_count: got fall=%0d any=%0d exp 1/1", fall_cnt, any_cnt);
    end
    bus.iSignal[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oAny} !== {m_lvl, m_rise, m_fall, m_any}) begin
        failures++; $display("FAIL release_model: cyc %0d got %b/%b/%b/%b exp %b/%b/%b/%b", i, bus.oLevel, bus.oRise, bus.oFall, bus.oAny, m_lvl, m_rise, m_fall, m_any);
      end
      if (bus.oLevel[0] === 1'b1 && first_high < 0) first_high = i;
      if (bus.oRise[0] === 1'b1) begin rise_cnt++; rise_at = i; end
    end
    checks++;
    if (first_high != LAT || rise_at != LAT || rise_cnt != 1) begin
      failures++; $display("FAIL release_rise: got level@%0d rise@%0d n=%0d exp %0d/%0d/1", first_high, rise_at, rise_cnt, LAT, LAT);
    end
    $display("test_clean_press done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_glitch();
    int pulses = 0, fall_cnt = 0, rise_cnt = 0;
    // too short: F-1 samples
    bus.iSignal[1] = 1'b0;
    for (int i = 0; i < 29; i++) begin
      if (i == F - 1) bus.iSignal[1] = 1'b1;
      @(negedge CLK);
      checks++;
      if (bus.oLevel[1] !== 1'b1 || bus.oLevel !== m_lvl) begin
        failures++; $display("FAIL glitch_level: cyc %0d got %b exp %b", i, bus.oLevel, m_lvl);
      end
      if (bus.oAny === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL glitch_pulses: got %0d exp 0", pulses);
    end
    // exactly F samples: accepted
    bus.iSignal[1] = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (i == F) bus.iSignal[1] = 1'b1;
      @(negedge CLK);
      checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oAny} !== {m_lvl, m_rise, m_fall, m_any}) begin
        failures++; $display("FAIL glitch_min_model: cyc %0d got %b/%b/%b/%b exp %b/%b/%b/%b", i, bus.oLevel, bus.oRise, bus.oFall, bus.oAny, m_lvl, m_rise, m_fall, m_any);
      end
      if (bus.oFall[1] === 1'b1) fall_cnt++;
      if (bus.oRise[1] === 1'b1) rise_cnt++;
    end
    checks++;
    if (fall_cnt != 1 || rise_cnt != 1) begin
      failures++; $display("FAIL glitch_min_accept: got fall=%0d rise=%0d exp 1/1", fall_cnt, rise_cnt);
    end
    $display("test_glitch done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_bounce();
    int fall_cnt = 0, fall_at = -1;
    for (int i = 0; i < 30; i++) begin
      bus.iSignal[2] = ((i / 3) % 2) == 1;
      @(negedge CLK);
      checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oAny} !== {m_lvl, m_rise, m_fall, m_any}) begin
        failures++; $display("FAIL bounce_model: cyc %0d got %b/%b/%b/%b exp %b/%b/%b/%b", i, bus.oLevel, bus.oRise, bus.oFall, bus.oAny, m_lvl, m_rise, m_fall, m_any);
      end
      if (bus.oFall[2] === 1'b1) fall_cnt++;
    end
    bus.iSignal[2] = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge CLK);
      checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oAny} !== {m_lvl, m_rise, m_fall, m_any}) begin
        failures++; $display("FAIL settle_model: cyc %0d got %b/%b/%b/%b exp %b/%b/%b/%b", i, bus.oLevel, bus.oRise, bus.oFall, bus.oAny, m_lvl, m_rise, m_fall, m_any);
      end
      if (bus.oFall[2] === 1'b1) begin fall_cnt++; fall_at = i; end
    end
    checks++;
    if (fall_cnt != 1 || fall_at != LAT) begin
      failures++; $display("FAIL bounce_fall: got n=%0d at %0d exp 1 at %0d", fall_cnt, fall_at, LAT);
    end
    bus.iSignal[2] = 1'b1;
    repeat (LAT + 3) @(negedge CLK);
    checks++;
    if (bus.oLevel !== 4'b1111) begin
      failures++; $display("FAIL bounce_restore: got %b exp 1111", bus.oLevel);
    end
    $display("test_bounce done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_simultaneous();
    int any_cnt = 0, fall_at = -1;
    logic [CH-1:0] fall_seen = '0;
    bus.iSignal = 4'b0110;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oAny} !== {m_lvl, m_rise, m_fall, m_any}) begin
        failures++; $display("FAIL simul_model: cyc %0d got %b/%b/%b/%b exp %b/%b/%b/%b", i, bus.oLevel, bus.oRise, bus.oFall, bus.oAny, m_lvl, m_rise, m_fall, m_any);
      end
      if (bus.oFall !== 4'b0000) begin fall_seen = bus.oFall; fall_at = i; end
      if (bus.oAny === 1'b1) any_cnt++;
    end
    checks++;
    if (fall_seen !== 4'b1001 || fall_at != LAT || any_cnt != 1) begin
      failures++; $display("FAIL simul_fall: got %b at %0d any=%0d exp 1001 at %0d any=1", fall_seen, fall_at, any_cnt, LAT);
    end
    bus.iSignal = 4'b1111;
    repeat (LAT + 3) @(negedge CLK);
    checks++;
    if (bus.oLevel !== 4'b1111) begin
      failures++; $display("FAIL simul_restore: got %b exp 1111", bus.oLevel);
    end
    $display("test_simultaneous done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_midcount_reset();
    int pulses = 0;
    bus.iSignal[1] = 1'b0;
    repeat (D + 6) @(negedge CLK);
    #2 RST_n = 1'b0;
    #1;
    checks++;
    if (bus.oLevel !== 4'b1111 || bus.oAny !== 1'b0 || bus.oFall !== 4'b0000) begin
      failures++; $display("FAIL midreset_state: got lvl=%b fall=%b any=%b exp 1111/0000/0", bus.oLevel, bus.oFall, bus.oAny);
    end
    bus.iSignal = 4'b1111;
    @(negedge CLK);
    RST_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oAny} !== {m_lvl, m_rise, m_fall, m_any}) begin
        failures++; $display("FAIL midreset_model: cyc %0d got %b/%b/%b/%b exp %b/%b/%b/%b", i, bus.oLevel, bus.oRise, bus.oFall, bus.oAny, m_lvl, m_rise, m_fall, m_any);
      end
      if (bus.oAny === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++; $display("FAIL midreset_pulses: got %0d exp 0", pulses);
    end
    $display("test_midcount_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_random();
    int hold [CH];
    int edges = 0;
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          bus.iSignal[c] = 1'($urandom_range(0, 1));
          hold[c] = int'($urandom_range(1, 2 * F));
        end
        hold[c]--;
      end
      @(negedge CLK);
      checks++;
      if ({bus.oLevel, bus.oRise, bus.oFall, bus.oAny} !== {m_lvl, m_rise, m_fall, m_any}) begin
        failures++; $display("FAIL random_model: cyc %0d got %b/%b/%b/%b exp %b/%b/%b/%b", i, bus.oLevel, bus.oRise, bus.oFall, bus.oAny, m_lvl, m_rise, m_fall, m_any);
      end
      if (m_any) edges++;
    end
    $display("test_random done accepted_edge_cycles=%0d checks=%0d failures=%0d", edges, checks, failures);
  endtask

  initial begin
    bus.iSignal = {CH{1'b1}};
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_midcount_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
